// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - six-way round-robin burst arbiter muxing requester data onto one output stream
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic [5:0]       ack,
  output logic [2:0]       sel,
  output logic             busy
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_sel;
  logic [3:0]       r_cnt;

  logic [2:0]       w_pick;
  logic             w_found;
  logic [WIDTH-1:0] w_data;
  logic             w_req_sel;
  logic             w_beat;
  logic [3:0]       w_cnt_inc;
  logic [2:0]       w_ptr_next;

  // Rotating priority search starting at r_ptr, wrapping 5 -> 0
  always_comb begin
    logic [3:0] w_sum;
    w_pick  = r_ptr;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < 6; k++) begin
      w_sum = {1'b0, r_ptr} + 4'(k);
      if (w_sum >= 4'd6) w_sum = w_sum - 4'd6;
      if (!w_found && req[w_sum[2:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[2:0];
      end
    end
  end

  // Select data and request bit of the granted requester; 6 and 7 never occur
  always_comb begin
    w_data    = '0;
    w_req_sel = 1'b0;
    case (r_sel)
      3'd0: begin w_data = d0; w_req_sel = req[0]; end
      3'd1: begin w_data = d1; w_req_sel = req[1]; end
      3'd2: begin w_data = d2; w_req_sel = req[2]; end
      3'd3: begin w_data = d3; w_req_sel = req[3]; end
      3'd4: begin w_data = d4; w_req_sel = req[4]; end
      3'd5: begin w_data = d5; w_req_sel = req[5]; end
      default: begin w_data = '0; w_req_sel = 1'b0; end
    endcase
  end

  assign res_valid  = (r_state == XFER) && w_req_sel;
  assign res        = res_valid ? w_data : '0;
  assign w_beat     = res_valid && res_ready;
  assign ack        = w_beat ? (6'b000001 << r_sel) : 6'b000000;
  assign sel        = r_sel;
  assign busy       = (r_state == XFER);
  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_ptr_next = (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;

  // Grant FSM: pick in IDLE, stream beats in XFER until burst limit or request drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_sel   <= 3'd0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_cnt   <= 4'd0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (!w_req_sel) begin
            r_state <= IDLE;
            r_ptr   <= w_ptr_next;
          end else if (w_beat) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == LP_MAX) begin
              r_state <= IDLE;
              r_ptr   <= w_ptr_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] req;
  logic [7:0] d0, d1, d2, d3, d4, d5;
  logic       res_ready;

  logic [7:0] res,  b_res;
  logic       res_valid, b_valid;
  logic [5:0] ack,  b_ack;
  logic [2:0] sel,  b_sel;
  logic       busy, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .res_ready(res_ready), .res(res), .res_valid(res_valid),
    .ack(ack), .sel(sel), .busy(busy)
  );

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .res_ready(res_ready), .res(b_res), .res_valid(b_valid),
    .ack(b_ack), .sel(b_sel), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] vals [6];
    vals = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    rst_n = 1'b0; req = '0; res_ready = 1'b1;
    d0 = 8'd0; d1 = 8'd0; d2 = 8'd0; d3 = 8'd0; d4 = 8'd0; d5 = 8'd0;

    // reset state
    @(negedge clk); #1;
    check("rst_valid", 32'(res_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_sel",   32'(sel), 0);
    check("rst_ack",   32'(ack), 0);
    check("rst_res",   32'(res), 0);

    // single requester 2, burst of 4, bubble, regrant
    @(negedge clk); rst_n = 1'b1; d2 = 8'd30; req = 6'b000100; #1;
    check("t1_latency", 32'(res_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("t1_valid", 32'(res_valid), 1);
      check("t1_res",   32'(res), 30);
      check("t1_ack",   32'(ack), 32'h04);
      check("t1_sel",   32'(sel), 2);
    end
    @(negedge clk); #1;
    check("t1_bubble_busy",  32'(busy), 0);
    check("t1_bubble_valid", 32'(res_valid), 0);
    @(negedge clk); #1;
    check("t1_regrant_busy", 32'(busy), 1);
    check("t1_regrant_sel",  32'(sel), 2);
    check("t1_regrant_res",  32'(res), 30);
    req = 6'b000000;

    // reset while requester 3 is mid-transfer
    @(negedge clk); d3 = 8'd40; req = 6'b001000; #1;
    check("t2_idle", 32'(busy), 0);
    @(negedge clk); #1;
    check("t2_sel",   32'(sel), 3);
    check("t2_valid", 32'(res_valid), 1);
    check("t2_res",   32'(res), 40);
    #2 rst_n = 1'b0; #1;
    check("t2_rst_valid", 32'(res_valid), 0);
    check("t2_rst_busy",  32'(busy), 0);
    check("t2_rst_ack",   32'(ack), 0);
    check("t2_rst_res",   32'(res), 0);
    check("t2_rst_sel",   32'(sel), 0);
    @(negedge clk); rst_n = 1'b1; d0 = 8'd10; req = 6'b001001; #1;
    check("t2_rel_busy", 32'(busy), 0);
    @(negedge clk); #1;
    check("t2_ptr0_sel", 32'(sel), 0);
    check("t2_ptr0_res", 32'(res), 10);
    req = 6'b000000;

    // backpressure on requester 1
    @(negedge clk); d1 = 8'd20; req = 6'b000010; res_ready = 1'b0; #1;
    check("t3_idle", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t3_stall_valid", 32'(res_valid), 1);
      check("t3_stall_res",   32'(res), 20);
      check("t3_stall_ack",   32'(ack), 0);
      check("t3_stall_sel",   32'(sel), 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); res_ready = 1'b1; #1;
      check("t3_beat_ack", 32'(ack), 32'h02);
      check("t3_beat_res", 32'(res), 20);
    end
    @(negedge clk); req = 6'b000000; #1;
    check("t3_done_busy", 32'(busy), 0);

    // requester 4 drops after two beats; other requests must not disturb it
    @(negedge clk); d4 = 8'd50; req = 6'b010000; #1;
    check("t4_idle", 32'(busy), 0);
    @(negedge clk); #1;
    check("t4_b1_sel", 32'(sel), 4);
    check("t4_b1_ack", 32'(ack), 32'h10);
    @(negedge clk); req = 6'b111111; #1;
    check("t4_b2_sel", 32'(sel), 4);
    check("t4_b2_res", 32'(res), 50);
    check("t4_b2_ack", 32'(ack), 32'h10);
    @(negedge clk); req = 6'b000000; #1;
    check("t4_drop_valid", 32'(res_valid), 0);
    check("t4_drop_ack",   32'(ack), 0);
    check("t4_drop_busy",  32'(busy), 1);

    // wrap: ptr is now 5
    @(negedge clk); d5 = 8'd60; d0 = 8'd10; req = 6'b100001; #1;
    check("t5_idle", 32'(busy), 0);
    @(negedge clk); #1;
    check("t5_first_sel", 32'(sel), 5);
    check("t5_first_res", 32'(res), 60);
    req = 6'b000001;
    @(negedge clk); #1;
    check("t5_bubble", 32'(busy), 0);
    @(negedge clk); #1;
    check("t5_second_sel", 32'(sel), 0);
    check("t5_second_res", 32'(res), 10);
    check("t5_second_ack", 32'(ack), 32'h01);
    req = 6'b000000;

    // fairness with single-beat bursts
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    d0 = 8'd10; d1 = 8'd20; d2 = 8'd30; d3 = 8'd40; d4 = 8'd50; d5 = 8'd60;
    req = 6'b111111; #1;
    check("t6_idle", 32'(b_busy), 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      check("t6_valid", 32'(b_valid), 1);
      check("t6_res",   32'(b_res), 32'(vals[i % 6]));
      check("t6_ack",   32'(b_ack), 32'(6'b000001 << (i % 6)));
      check("t6_sel",   32'(b_sel), 32'(i % 6));
      @(negedge clk); #1;
      check("t6_bubble", 32'(b_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
